instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Microcode sequencer and control unit for the 8-bit computer. Steps a T-state counter,
//  decodes the 4-bit opcode from the instruction register and drives the 16-bit control
//  word that sequences the 4-bit program counter, MAR, RAM, IR, A/B registers, ALU and
//  output register over the shared bus. Owns halt and single-step (run) gating.
// PARAMETERS
//  OPCODE_W  4  opcode width (IR upper nibble)
//  STEP_W    3  T-state counter width
//  MAX_STEP  4  last legal T-state index (T0..T4)
// PORTS
//  clk       in   1   system clock; all state updates on posedge
//  clr_n     in   1   synchronous, active-low reset
//  run       in   1   1 = advance one T-state per clock; 0 = freeze
//  opcode    in   4   IR[7:4]; valid from T2 onward
//  carry_f   in   1   registered ALU carry flag
//  zero_f    in   1   registered ALU zero flag
//  ctrl      out  16  control word; bit map below
//  step      out  3   current T-state (debug/display)
//  halted    out  1   1 after HLT executes, until reset
// BEHAVIOUR
//  ctrl bits: 0 pc_inc, 1 pc_oe, 2 pc_jmp, 3 pc_clr, 4 mar_in, 5 ram_oe, 6 ram_in, 7 ir_in,
//   8 ir_oe, 9 a_in, 10 a_oe, 11 b_in, 12 alu_oe, 13 alu_sub, 14 flags_in, 15 out_in.
//  step, halted registered; ctrl combinational from (step, opcode, flags, halted, run, clr_n).
//  Reset: while clr_n=0, ctrl=16'h0008 (pc_clr only); at the edge step<=0, halted<=0.
//  Fetch: T0 pc_oe|mar_in; T1 ram_oe|ir_in|pc_inc (opcode valid from T2).
//  Execute (unlisted steps = 0; last listed step returns step to 0 at the next edge):
//   0 NOP: T2 empty.                  1 LDA: T2 ir_oe|mar_in; T3 ram_oe|a_in.
//   2 ADD: T2 ir_oe|mar_in; T3 ram_oe|b_in; T4 alu_oe|a_in|flags_in.
//   3 SUB: same as ADD, with alu_sub also set in T4.
//   4 STA: T2 ir_oe|mar_in; T3 a_oe|ram_in.  5 LDI: T2 ir_oe|a_in.
//   6 JMP: T2 ir_oe|pc_jmp.           14 OUT: T2 a_oe|out_in.
//   15 HLT: T2 ctrl=0; halted<=1 at the edge.   9..13: as NOP (T2 empty).
//   7 JC / 8 JZ: see CONFIGURATION.
//  Instruction length: 3 cycles (NOP/LDI/JMP/OUT/HLT/J*), 4 (LDA/STA), 5 (ADD/SUB).
//  step never exceeds MAX_STEP. Reaching MAX_STEP forces a wrap to 0.
//  run=0: step holds; ctrl=0 (no pc_inc, no latches); on run=1 resumes at the held step.
//  halted=1: ctrl=0, step forced to 0 and held; run ignored; only clr_n=0 clears it.
//  clr_n=0 mid-instruction aborts: next cycle is T0 of a fresh fetch. Reset beats run/halt.
//  Invariant: at most one of {pc_oe, ram_oe, ir_oe, a_oe, alu_oe} set in any cycle.
//  Flags are sampled combinationally in T2 only.
// CONFIGURATION
//  SEQ_COND_JUMP_EN defined: JC T2 = ir_oe|pc_jmp if carry_f else 0;
//   JZ T2 = ir_oe|pc_jmp if zero_f else 0; both are 3-cycle instructions either way.
//  Not defined: opcodes 7, 8 decode as NOP; carry_f/zero_f unused.
// STRUCTURE
//  seq_pkg: opcode localparams (OP_NOP..OP_HLT), CTRL_* bit indices, CTRL_W=16, T0..T4.
//  Sub-module seq_ucode_rom: purely combinational (step, opcode, flags) -> {ctrl, last}.
//  Top holds the step/halted registers, run/halt/reset gating and the wrap logic.
// TESTING
//  Reset: clr_n=0 for 2 clk -> ctrl=16'h0008, step=0, halted=0. Release -> T0 ctrl=16'h0012.
//  ADD (opcode 2), run=1: steps 0,1,2,3,4,0. T4 ctrl=16'h5200; SUB T4 = 16'h7200.
//  run=0 at T3 of LDA for 3 clk: step stays 3, ctrl=0. run=1 -> T3 ctrl=16'h0220, then T0.
//  HLT: after T2 edge, halted=1, step=0, ctrl=0 for 10 clk with run=1. clr_n pulse clears.
//  With SEQ_COND_JUMP_EN: JC carry_f=1 -> T2 ctrl=16'h0104; carry_f=0 -> ctrl=0.
//   Without the macro, JC T2 ctrl=0.
//  clr_n=0 at T3 of STA -> no ram_in that cycle; step=0 next. Random opcodes: bus one-hot-or-zero check.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 8-bit computer microcode sequencer: control-word
// bit positions, opcode encodings and T-state names.
package seq_pkg;

  localparam int CTRL_W = 16;

  localparam int unsigned CTRL_PC_INC   = 0;
  localparam int unsigned CTRL_PC_OE    = 1;
  localparam int unsigned CTRL_PC_JMP   = 2;
  localparam int unsigned CTRL_PC_CLR   = 3;
  localparam int unsigned CTRL_MAR_IN   = 4;
  localparam int unsigned CTRL_RAM_OE   = 5;
  localparam int unsigned CTRL_RAM_IN   = 6;
  localparam int unsigned CTRL_IR_IN    = 7;
  localparam int unsigned CTRL_IR_OE    = 8;
  localparam int unsigned CTRL_A_IN     = 9;
  localparam int unsigned CTRL_A_OE     = 10;
  localparam int unsigned CTRL_B_IN     = 11;
  localparam int unsigned CTRL_ALU_OE   = 12;
  localparam int unsigned CTRL_ALU_SUB  = 13;
  localparam int unsigned CTRL_FLAGS_IN = 14;
  localparam int unsigned CTRL_OUT_IN   = 15;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
    return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/seq_ucode_rom.sv
// Combinational microcode table: (T-state, opcode, flags) -> control word plus
// a "last step of this instruction" marker. Optional macro: SEQ_COND_JUMP_EN.
module seq_ucode_rom
  import seq_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  tstate_e             step_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                carry_i,
  input  logic                zero_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                last_o
);

`ifndef SEQ_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry_i ^ zero_i;
`endif

  always_comb begin
    ctrl_o = '0;
    last_o = 1'b0;
    case (step_i)
      T0: ctrl_o = cbit(CTRL_PC_OE) | cbit(CTRL_MAR_IN);
      T1: ctrl_o = cbit(CTRL_RAM_OE) | cbit(CTRL_IR_IN) | cbit(CTRL_PC_INC);
      T2: begin
        last_o = 1'b1;
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o = cbit(CTRL_IR_OE) | cbit(CTRL_MAR_IN);
            last_o = 1'b0;
          end
          OP_LDI: ctrl_o = cbit(CTRL_IR_OE) | cbit(CTRL_A_IN);
          OP_JMP: ctrl_o = cbit(CTRL_IR_OE) | cbit(CTRL_PC_JMP);
`ifdef SEQ_COND_JUMP_EN
          OP_JC: if (carry_i) ctrl_o = cbit(CTRL_IR_OE) | cbit(CTRL_PC_JMP);
          OP_JZ: if (zero_i)  ctrl_o = cbit(CTRL_IR_OE) | cbit(CTRL_PC_JMP);
`endif
          OP_OUT: ctrl_o = cbit(CTRL_A_OE) | cbit(CTRL_OUT_IN);
          default: ;
        endcase
      end
      T3: begin
        last_o = 1'b1;
        case (opcode_i)
          OP_LDA: ctrl_o = cbit(CTRL_RAM_OE) | cbit(CTRL_A_IN);
          OP_STA: ctrl_o = cbit(CTRL_A_OE) | cbit(CTRL_RAM_IN);
          OP_ADD, OP_SUB: begin
            ctrl_o = cbit(CTRL_RAM_OE) | cbit(CTRL_B_IN);
            last_o = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        last_o = 1'b1;
        if (opcode_i == OP_ADD || opcode_i == OP_SUB)
          ctrl_o = cbit(CTRL_ALU_OE) | cbit(CTRL_A_IN) | cbit(CTRL_FLAGS_IN);
        if (opcode_i == OP_SUB)
          ctrl_o = ctrl_o | cbit(CTRL_ALU_SUB);
      end
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Microcode sequencer top: T-state counter, halt latch, run/reset gating of the
// control word. Optional macro: SEQ_COND_JUMP_EN (conditional JC/JZ).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int MAX_STEP = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_f,
  input  logic                zero_f,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [STEP_W-1:0]   step,
  output logic                halted
);

  tstate_e           step_q, step_d;
  logic              halted_q, halted_d;
  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;

  seq_ucode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .step_i   (step_q),
    .opcode_i (opcode),
    .carry_i  (carry_f),
    .zero_i   (zero_f),
    .ctrl_o   (rom_ctrl),
    .last_o   (rom_last)
  );

  // Wrap on the instruction's last step, and unconditionally at MAX_STEP.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = T0;
    end else if (run) begin
      if (rom_last || int'(step_q) >= MAX_STEP)
        step_d = T0;
      else
        step_d = tstate_e'(step_q + 3'd1);
      if (step_q == T2 && opcode == OP_HLT)
        halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    if (!clr_n)
      ctrl = cbit(CTRL_PC_CLR);
    else if (halted_q || !run)
      ctrl = '0;
    else
      ctrl = rom_ctrl;
  end

  assign step   = STEP_W'(step_q);
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, halt/reset
// sequence, and randomized run against an instruction-level reference model.
module tb_instr_sequencer;

`ifdef SEQ_COND_JUMP_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif
  localparam logic [15:0] JC_T2 = COND_EN ? 16'h0104 : 16'h0000;

  logic        clk = 1'b0;
  logic        clr_n, run, carry_f, zero_f;
  logic [3:0]  opcode;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.OPCODE_W(4), .STEP_W(3), .MAX_STEP(4)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .run     (run),
    .opcode  (opcode),
    .carry_f (carry_f),
    .zero_f  (zero_f),
    .ctrl    (ctrl),
    .step    (step),
    .halted  (halted)
  );

  typedef struct {
    logic        clr_n;
    logic        run;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
  } vec_t;

  vec_t vecs[$];

  // Instruction-level model: execute-phase words per opcode and total length.
  logic [15:0] prog[16][3];
  int          ilen[16];
  int          m_step;
  bit          m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic cl, input logic r, input logic [3:0] op, input logic c,
                     input logic z, input logic [15:0] cw, input logic [2:0] st, input logic h);
    vec_t v;
    v.clr_n = cl; v.run = r; v.op = op; v.c = c; v.z = z;
    v.ctrl = cw; v.step = st; v.halted = h;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic cl, input logic r, input logic [3:0] op,
                       input logic c, input logic z);
    clr_n = cl; run = r; opcode = op; carry_f = c; zero_f = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_word(input int op, input int t, input bit c, input bit z);
    if (t == 0) return 16'h0012;
    if (t == 1) return 16'h00A1;
    if (t >= ilen[op]) return 16'h0000;
    if (op == 7 && !(COND_EN && c)) return 16'h0000;
    if (op == 8 && !(COND_EN && z)) return 16'h0000;
    return prog[op][t-2];
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
    if (o == 4'd15 && $urandom_range(0, 3) != 0) o = 4'($urandom_range(0, 14));
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ilen[i] = 3;
      for (int k = 0; k < 3; k++) prog[i][k] = 16'h0000;
    end
    prog[1]  = '{16'h0110, 16'h0220, 16'h0000};  ilen[1] = 4;
    prog[2]  = '{16'h0110, 16'h0820, 16'h5200};  ilen[2] = 5;
    prog[3]  = '{16'h0110, 16'h0820, 16'h7200};  ilen[3] = 5;
    prog[4]  = '{16'h0110, 16'h0440, 16'h0000};  ilen[4] = 4;
    prog[5][0]  = 16'h0300;
    prog[6][0]  = 16'h0104;
    prog[7][0]  = 16'h0104;
    prog[8][0]  = 16'h0104;
    prog[14][0] = 16'h8400;

    // clr, run, op, c, z, ctrl, step, halted
    add(0,1, 0,0,0, 16'h0008,0,0);  add(0,1, 0,0,0, 16'h0008,0,0);
    add(1,1, 2,0,0, 16'h0012,0,0);  add(1,1, 2,0,0, 16'h00A1,1,0);
    add(1,1, 2,0,0, 16'h0110,2,0);  add(1,1, 2,0,0, 16'h0820,3,0);
    add(1,1, 2,0,0, 16'h5200,4,0);
    add(1,1, 3,0,0, 16'h0012,0,0);  add(1,1, 3,0,0, 16'h00A1,1,0);
    add(1,1, 3,0,0, 16'h0110,2,0);  add(1,1, 3,0,0, 16'h0820,3,0);
    add(1,1, 3,0,0, 16'h7200,4,0);
    add(1,1, 1,0,0, 16'h0012,0,0);  add(1,1, 1,0,0, 16'h00A1,1,0);
    add(1,1, 1,0,0, 16'h0110,2,0);  add(1,0, 1,0,0, 16'h0000,3,0);
    add(1,0, 1,0,0, 16'h0000,3,0);  add(1,0, 1,0,0, 16'h0000,3,0);
    add(1,1, 1,0,0, 16'h0220,3,0);  add(1,1, 1,0,0, 16'h0012,0,0);
    add(1,1, 4,0,0, 16'h00A1,1,0);  add(1,1, 4,0,0, 16'h0110,2,0);
    add(0,1, 4,0,0, 16'h0008,3,0);  add(1,1, 4,0,0, 16'h0012,0,0);
    add(1,1, 6,0,0, 16'h00A1,1,0);  add(1,1, 6,0,0, 16'h0104,2,0);
    add(1,1,14,0,0, 16'h0012,0,0);  add(1,1,14,0,0, 16'h00A1,1,0);
    add(1,1,14,0,0, 16'h8400,2,0);
    add(1,1, 5,0,0, 16'h0012,0,0);  add(1,1, 5,0,0, 16'h00A1,1,0);
    add(1,1, 5,0,0, 16'h0300,2,0);
    add(1,1, 7,1,0, 16'h0012,0,0);  add(1,1, 7,1,0, 16'h00A1,1,0);
    add(1,1, 7,1,0, JC_T2,  2,0);
    add(1,1, 7,0,1, 16'h0012,0,0);  add(1,1, 7,0,1, 16'h00A1,1,0);
    add(1,1, 7,0,1, 16'h0000,2,0);
    add(1,1, 8,0,1, 16'h0012,0,0);  add(1,1, 8,0,1, 16'h00A1,1,0);
    add(1,1, 8,0,1, JC_T2,  2,0);
    add(1,1,11,1,1, 16'h0012,0,0);  add(1,1,11,1,1, 16'h00A1,1,0);
    add(1,1,11,1,1, 16'h0000,2,0);
    add(1,1,15,0,0, 16'h0012,0,0);  add(1,1,15,0,0, 16'h00A1,1,0);
    add(1,1,15,0,0, 16'h0000,2,0);  add(1,1,15,0,0, 16'h0000,0,1);
    add(1,1, 2,0,0, 16'h0000,0,1);  add(0,1, 2,0,0, 16'h0008,0,1);
    add(1,1, 2,0,0, 16'h0012,0,0);

    drive(0, 1, 4'd0, 0, 0);
    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].clr_n, vecs[i].run, vecs[i].op, vecs[i].c, vecs[i].z);
      #1;
      check($sformatf("vec%0d_ctrl", i),   32'(ctrl),   32'(vecs[i].ctrl));
      check($sformatf("vec%0d_step", i),   32'(step),   32'(vecs[i].step));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].halted));
      tick();
    end

    // Halt held for 10 clocks with run toggling, then cleared by a reset pulse.
    drive(1, 1, 4'd15, 0, 0);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1, 1);
      #1;
      check("halt_hold_ctrl",   32'(ctrl),   32'h0);
      check("halt_hold_step",   32'(step),   32'h0);
      check("halt_hold_halted", 32'(halted), 32'h1);
      tick();
    end
    drive(0, 1, 4'd0, 0, 0);
    #1;
    check("halt_clr_ctrl", 32'(ctrl), 32'h0008);
    tick();
    drive(1, 1, 4'd0, 0, 0);
    #1;
    check("halt_release_ctrl",   32'(ctrl),   32'h0012);
    check("halt_release_halted", 32'(halted), 32'h0);

    // Randomized run against the instruction-level model.
    drive(0, 1, 4'd0, 0, 0);
    tick();
    m_step = 0;
    m_halted = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] exp_ctrl;
      logic [3:0]  op_n;
      op_n = (m_step <= 1) ? pick_op() : opcode;
      drive(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0), op_n,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      if (!clr_n)             exp_ctrl = 16'h0008;
      else if (m_halted || !run) exp_ctrl = 16'h0000;
      else                    exp_ctrl = ref_word(int'(opcode), m_step, carry_f, zero_f);
      check("rnd_ctrl",   32'(ctrl),   32'(exp_ctrl));
      check("rnd_step",   32'(step),   32'(m_step));
      check("rnd_halted", 32'(halted), 32'(m_halted));
      check("rnd_bus_onehot", 32'($countones(ctrl & 16'h1522) <= 1), 32'h1);
      @(posedge clk);
      if (!clr_n) begin
        m_step = 0; m_halted = 0;
      end else if (m_halted) begin
        m_step = 0;
      end else if (run) begin
        if (m_step == 2 && opcode == 4'd15) m_halted = 1;
        m_step = m_step + 1;
        if (m_step >= ilen[opcode]) m_step = 0;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
